spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- SPI master transmitter that drives the panel-side SPI byte receiver: it buffers bytes from the host logic in a small FIFO and serialises them MSB-first on sck/sdo.
- Generates sck by dividing clk. Mode 0: sck idles low, sdo changes while sck is low, the receiver samples on sck rising and counts bytes on sck falling.
- No chip select. Byte framing relies on both ends leaving reset together and on the master always emitting exactly 8 sck periods per byte.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal range 1..255.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- GAP_CYCLES, 0, idle clk cycles with sck low inserted between consecutive bytes; legal range 0..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte; equals not-full.
- sck  out  1  SPI serial clock, registered.
- sdo  out  1  SPI serial data to the receiver's sdi, registered.
- busy  out  1  high when the FIFO is non-empty or the state is not IDLE.
- byte_done  out  1  one-cycle pulse on the clk edge where the 8th sck falling edge of a byte occurs.

Behaviour:
- Reset (asynchronous): sck=0, sdo=0, byte_done=0, FIFO emptied, state=IDLE, counters=0. Therefore in_ready=1 and busy=0 both during and after reset. Reset mid-byte abandons the byte immediately, with no trailing sck edges.
- FIFO push: occurs on a clk edge when in_valid && in_ready. When full, in_ready=0 and in_valid is ignored with no overwrite.
- FIFO pop: occurs only in the LOAD action. A push and a pop on the same edge are both honoured. Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.
- States: IDLE, LOW, HIGH, GAP.
- LOAD action: pop the FIFO head into an 8-bit shift register, sdo<=bit7, bit_cnt<=0, div_cnt<=0, state<=LOW.
- IDLE: sck=0. If the FIFO is non-empty, perform LOAD. Otherwise sdo<=0.
- LOW: sck=0. div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1: sck<=1, div_cnt<=0, state<=HIGH.
- HIGH: sck=1. At div_cnt CLK_DIV-1: sck<=0 and div_cnt<=0, then:
  - If bit_cnt<7: shift left, sdo<=next bit, bit_cnt+1, state<=LOW.
  - If bit_cnt==7: byte_done<=1. If GAP_CYCLES==0 and the FIFO is non-empty, perform LOAD on this same edge (back-to-back bytes with no extra cycle). If GAP_CYCLES==0 and the FIFO is empty, sdo<=0 and state<=IDLE. If GAP_CYCLES>0, sdo<=0 and state<=GAP.
- GAP: sck=0. Count GAP_CYCLES cycles, then go to IDLE. IDLE then performs LOAD on the next edge if data is present.
- Timing:
  - Push accepted at edge E0 with the master idle and FIFO empty: the data is visible in the FIFO after E0, LOAD happens at E1, and sdo=bit7 from E1.
  - First sck rise at E1+CLK_DIV.
  - One byte occupies 16*CLK_DIV clk cycles, from LOAD to the 8th falling edge.
  - Back-to-back throughput is 16*CLK_DIV + GAP_CYCLES (+1 if GAP_CYCLES>0, for the IDLE->LOAD cycle) clk cycles per byte.
- Guarantees:
  - sdo only changes on edges where sck is low or falls, so it is stable for the whole sck-high phase.
  - sck and sdo are glitch-free flop outputs.

Test Plan:
- Reset, CLK_DIV=4: push 0xA5 at E0 -> sdo=1 from E1, sck first rises at E1+4; the bits sampled on sck rise are 1,0,1,0,0,1,0,1; byte_done pulses once at E1+64; afterwards sck=0, sdo=0, busy=0.
- Push 0x3C,0xFF,0x00 in consecutive cycles with GAP_CYCLES=0 -> exactly 24 sck rising edges with no extra cycles between bytes; the received bytes, checked by a behavioural receiver model, are 0x3C,0xFF,0x00; three byte_done pulses 64 cycles apart.
- FIFO_DEPTH=4, hold in_valid with 6 distinct bytes while the master is transmitting -> in_ready drops when full; no byte is lost or duplicated; all 6 bytes are received in order.
- GAP_CYCLES=3, two bytes queued -> sck stays low for 3 GAP cycles plus 1 IDLE cycle between the 8th falling edge and the next LOAD; sdo=0 during the gap.
- Assert reset during bit 3 of a byte with 2 bytes queued -> sck=0 and sdo=0 immediately; busy=0; no further sck edges. After release, push 0x81 -> transmitted correctly, starting from bit 7.
- CLK_DIV=1 -> sck toggles every clk cycle, and 0x5A is received intact.

Source files
------------

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master transmitter: a small byte FIFO feeding an MSB-first serialiser.
// sck is derived from clk by CLK_DIV; optional GAP_CYCLES idle time between bytes.
module spi_master_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sck,
    output logic       sdo,
    output logic       busy,
    output logic       byte_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } state_t;

    state_t      state, state_n;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, load, shift;
    logic [7:0]  head, shreg;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  div_cnt, div_cnt_n;
    logic [7:0]  gap_cnt, gap_cnt_n;
    logic        sck_n, sdo_n, done_n;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign busy       = !fifo_empty || (state != IDLE);
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        sck_n     = sck;
        sdo_n     = sdo;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        gap_cnt_n = gap_cnt;
        done_n    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                sck_n = 1'b0;
                if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    sdo_n = 1'b0;
                end
            end
            LOW: begin
                if (div_cnt == DIV_LAST) begin
                    sck_n     = 1'b1;
                    div_cnt_n = 8'd0;
                    state_n   = HIGH;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    sck_n     = 1'b0;
                    div_cnt_n = 8'd0;
                    if (bit_cnt != 3'd7) begin
                        shift     = 1'b1;
                        sdo_n     = shreg[6];
                        bit_cnt_n = bit_cnt + 3'd1;
                        state_n   = LOW;
                    end else begin
                        done_n = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            sdo_n     = 1'b0;
                            gap_cnt_n = 8'd0;
                            state_n   = GAP;
                        end else if (!fifo_empty) begin
                            // Back-to-back: next byte loads on the same falling edge.
                            load = 1'b1;
                        end else begin
                            sdo_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            GAP: begin
                sck_n = 1'b0;
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = 8'd0;
                    state_n   = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            sdo_n     = head[7];
            bit_cnt_n = 3'd0;
            div_cnt_n = 8'd0;
            state_n   = LOW;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sck       <= 1'b0;
            sdo       <= 1'b0;
            byte_done <= 1'b0;
            bit_cnt   <= 3'd0;
            div_cnt   <= 8'd0;
            gap_cnt   <= 8'd0;
        end else begin
            state     <= state_n;
            sck       <= sck_n;
            sdo       <= sdo_n;
            byte_done <= done_n;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            gap_cnt   <= gap_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= head;
        end else if (shift) begin
            shreg <= {shreg[6:0], 1'b0};
        end
    end

endmodule
